// File: rtl/shift_load_ctrl.sv
// Serialises a parallel word into a downstream shift register, one bit per divider tick,
// with an optional clear pulse before the first shift and a one-cycle completion pulse.
module shift_load_ctrl #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          CLR_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       tick,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       abort,
    output logic                       sdout,
    output logic                       shift_en,
    output logic                       shreg_clr,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

    localparam int unsigned     CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sdout_q;
    logic             start_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             shreg_clr_q;
    logic             accept;
    logic             shift_fire;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign accept = start_valid && start_ready_q;
    // Masked by clr so a reset landing mid-transfer cannot emit a stray shift.
    assign shift_fire = tick && (state_q == SHIFT) && !abort && !clr;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d = data_in;
                    cnt_d  = '0;
                    if (CLR_FIRST) state_d = LOAD;
                    else           state_d = SHIFT;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    word_d  = '0;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    word_d  = '0;
                end else if (shift_fire) begin
                    word_d = advance(word_q);
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_MAX - CNT_ONE) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= IDLE;
            word_q        <= '0;
            cnt_q         <= '0;
            sdout_q       <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            shreg_clr_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            cnt_q         <= cnt_d;
            sdout_q       <= head_bit(word_d);
            start_ready_q <= (state_d == IDLE);
            busy_q        <= (state_d != IDLE);
            done_q        <= (state_d == DONE);
            shreg_clr_q   <= (state_d == LOAD);
        end
    end

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign shreg_clr   = shreg_clr_q;
    assign sdout       = sdout_q;
    assign shift_en    = shift_fire;
    assign bit_cnt     = cnt_q;

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Scoreboard bench for shift_load_ctrl: two instances (MSB-first with clear, LSB-first without),
// expected serial events queued at each handshake and consumed by a negedge monitor.
module tb_shift_load_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic       tick[2];
    logic       start_valid[2];
    logic       start_ready[2];
    logic [W-1:0] data_in[2];
    logic       abort[2];
    logic       sdout[2];
    logic       shift_en[2];
    logic       shreg_clr[2];
    logic       busy[2];
    logic       done[2];
    logic [2:0] bit_cnt[2];

    shift_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1), .CLR_FIRST(1'b1)) dut0 (
        .clk(clk), .clr(clr), .tick(tick[0]), .start_valid(start_valid[0]),
        .start_ready(start_ready[0]), .data_in(data_in[0]), .abort(abort[0]),
        .sdout(sdout[0]), .shift_en(shift_en[0]), .shreg_clr(shreg_clr[0]),
        .busy(busy[0]), .done(done[0]), .bit_cnt(bit_cnt[0])
    );

    shift_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0), .CLR_FIRST(1'b0)) dut1 (
        .clk(clk), .clr(clr), .tick(tick[1]), .start_valid(start_valid[1]),
        .start_ready(start_ready[1]), .data_in(data_in[1]), .abort(abort[1]),
        .sdout(sdout[1]), .shift_en(shift_en[1]), .shreg_clr(shreg_clr[1]),
        .busy(busy[1]), .done(done[1]), .bit_cnt(bit_cnt[1])
    );

    function automatic bit msbf(input int i);
        return (i == 0);
    endfunction

    function automatic int clrf(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // tick modes: 0 every cycle, 3 every third cycle, 9 random, other values none
    int tick_mode[2] = '{-1, -1};
    int tdiv[2] = '{0, 0};
    initial begin
        tick[0] = 1'b0;
        tick[1] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                case (tick_mode[i])
                    0: tick[i] = 1'b1;
                    3: begin
                        tdiv[i] = (tdiv[i] + 1) % 3;
                        tick[i] = (tdiv[i] == 0);
                    end
                    9: tick[i] = 1'($urandom_range(0, 1));
                    default: tick[i] = 1'b0;
                endcase
            end
        end
    end

    typedef struct {
        bit           is_done;
        bit           b;
        logic [W-1:0] word;
        int           exp_cyc;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    function automatic void push_ev(input int i, input ev_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ev_t pop_ev(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    int           shifts[2]     = '{0, 0};
    int           clrs[2]       = '{0, 0};
    int           last_shift[2] = '{0, 0};
    int           done_cnt[2]   = '{0, 0};
    logic [W-1:0] qm[2];

    task automatic mon(input int i);
        ev_t e;
        check("ready_vs_busy", int'(start_ready[i]), int'(!busy[i]));
        if (shift_en[i] || shreg_clr[i])
            check("clr_shift_excl", int'(shift_en[i] & shreg_clr[i]), 0);
        if (start_valid[i] && start_ready[i] && !clr) begin
            shifts[i] = 0;
            clrs[i]   = 0;
            qm[i]     = '0;
        end
        if (shreg_clr[i]) clrs[i]++;
        if (shift_en[i]) begin
            if (qsize(i) == 0) begin
                check("unexpected_shift", 1, 0);
            end else begin
                e = pop_ev(i);
                check("shift_kind", int'(e.is_done), 0);
                check("sdout", int'(sdout[i]), int'(e.b));
            end
            if (msbf(i)) qm[i] = {qm[i][W-2:0], sdout[i]};
            else         qm[i] = {sdout[i], qm[i][W-1:1]};
            shifts[i]++;
            last_shift[i] = cyc;
        end
        if (done[i]) begin
            done_cnt[i]++;
            if (qsize(i) == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = pop_ev(i);
                check("done_kind", int'(e.is_done), 1);
                check("done_word", int'(qm[i]), int'(e.word));
                check("done_shift_count", shifts[i], W);
                check("done_clr_pulses", clrs[i], clrf(i));
                check("done_bit_cnt", int'(bit_cnt[i]), W);
                check("done_after_last_shift", cyc, last_shift[i] + 1);
                if (e.exp_cyc >= 0) check("done_cycle", cyc, e.exp_cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) mon(i);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input int i);
        check("rst_start_ready", int'(start_ready[i]), 1);
        check("rst_busy", int'(busy[i]), 0);
        check("rst_done", int'(done[i]), 0);
        check("rst_shift_en", int'(shift_en[i]), 0);
        check("rst_shreg_clr", int'(shreg_clr[i]), 0);
        check("rst_sdout", int'(sdout[i]), 0);
        check("rst_bit_cnt", int'(bit_cnt[i]), 0);
    endtask

    // Call just after a rising edge; returns just after the handshake edge (cycle t_hs+1).
    task automatic send(input int i, input logic [W-1:0] w, input bit every,
                        input int nshift, input bit with_done, output int t_hs);
        ev_t e;
        bit  ok;
        ok   = 1'b0;
        t_hs = -1;
        start_valid[i] = 1'b1;
        data_in[i]     = w;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (start_ready[i]) begin
                ok   = 1'b1;
                t_hs = cyc;
            end
        end
        if (!ok) begin
            check("handshake_timeout", 0, 1);
        end else begin
            for (int k = 0; k < nshift; k++) begin
                e.is_done = 1'b0;
                e.b       = msbf(i) ? w[W-1-k] : w[k];
                e.word    = w;
                e.exp_cyc = -1;
                push_ev(i, e);
            end
            if (with_done) begin
                e.is_done = 1'b1;
                e.b       = 1'b0;
                e.word    = w;
                e.exp_cyc = every ? t_hs + clrf(i) + W + 1 : -1;
                push_ev(i, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int i, output int t);
        bit ok;
        ok = 1'b0;
        t  = -1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (start_ready[i]) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
        if (!ok) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    initial begin
        int           t, t2, dsave;
        logic [W-1:0] w, w2;

        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_valid[i] = 1'b0;
            abort[i]       = 1'b0;
            data_in[i]     = '0;
            qm[i]          = '0;
        end
        cycles(3);
        @(negedge clk);
        check_reset(0);
        check_reset(1);
        @(posedge clk);
        #1;
        clr = 1'b0;

        // MSB first with clear, tick every third cycle
        tick_mode[0] = 3;
        send(0, 4'b1011, 1'b0, W, 1'b1, t);
        start_valid[0] = 1'b0;
        wait_ready(0, t2);

        // LSB first without clear, tick every cycle
        tick_mode[1] = 0;
        send(1, 4'b0001, 1'b1, W, 1'b1, t);
        start_valid[1] = 1'b0;
        wait_ready(1, t2);
        check("ready_latency_1", t2, t + clrf(1) + W + 2);

        tick_mode[0] = 0;
        send(0, 4'b0110, 1'b1, W, 1'b1, t);
        start_valid[0] = 1'b0;
        wait_ready(0, t2);
        check("ready_latency_0", t2, t + clrf(0) + W + 2);

        // abort on the second shifting tick
        for (int i = 0; i < 2; i++) begin
            tick_mode[i] = 0;
            dsave = done_cnt[i];
            send(i, 4'b1101, 1'b1, 1, 1'b0, t);
            start_valid[i] = 1'b0;
            cycles(clrf(i) + 1);
            abort[i] = 1'b1;
            cycles(1);
            abort[i] = 1'b0;
            @(negedge clk);
            check("abort_bit_cnt", int'(bit_cnt[i]), 1);
            check("abort_start_ready", int'(start_ready[i]), 1);
            check("abort_busy", int'(busy[i]), 0);
            cycles(6);
            check("abort_no_done", done_cnt[i], dsave);
        end

        // start_valid held high across two words, data changed while shifting
        for (int i = 0; i < 2; i++) begin
            tick_mode[i] = 0;
            w  = 4'($urandom);
            w2 = ~w;
            send(i, w, 1'b1, W, 1'b1, t);
            data_in[i] = w2;
            send(i, w2, 1'b1, W, 1'b1, t2);
            check("b2b_accept_cycle", t2, t + clrf(i) + W + 2);
            start_valid[i] = 1'b0;
            wait_ready(i, t2);
        end

        // reset held two cycles in the middle of a transfer
        tick_mode[0] = 0;
        send(0, 4'b1110, 1'b1, W, 1'b1, t);
        start_valid[0] = 1'b0;
        cycles(2);
        q0.delete();
        dsave = done_cnt[0];
        clr = 1'b1;
        cycles(1);
        @(negedge clk);
        check_reset(0);
        check_reset(1);
        @(posedge clk);
        #1;
        clr = 1'b0;
        cycles(8);
        check("reset_no_done", done_cnt[0], dsave);
        @(negedge clk);
        check("post_reset_bit_cnt", int'(bit_cnt[0]), 0);
        @(posedge clk);
        #1;

        // randomized words, random ticks, random gaps and data noise
        for (int i = 0; i < 2; i++) begin
            tick_mode[i] = 9;
            for (int n = 0; n < 12; n++) begin
                w = 4'($urandom);
                send(i, w, 1'b0, W, 1'b1, t);
                if ($urandom_range(0, 1) == 1) begin
                    start_valid[i] = 1'b0;
                    data_in[i]     = 4'($urandom);
                    wait_ready(i, t2);
                    cycles(int'($urandom_range(0, 3)));
                end
            end
            start_valid[i] = 1'b0;
            wait_ready(i, t2);
        end

        cycles(5);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_load_ctrl.md
# shift_load_ctrl

Sequencer that loads a parallel word into the serial shift register one bit per divided-clock tick. It accepts a word over a valid/ready handshake and, if enabled, clears the downstream register first. It then drives the serial data bit and a one-cycle shift enable for exactly WIDTH ticks and reports completion. It sits between the system-side command logic and the clock-divider/shift-register pair, running on the fast clock and using the divider output as a tick enable.

## Interface
- WIDTH, 4, number of bits per word and shift-register length (2..16)
- MSB_FIRST, 1, 1: shift data_in[WIDTH-1] first; 0: shift data_in[0] first
- CLR_FIRST, 1, 1: pulse shreg_clr for one cycle before shifting; 0: skip LOAD state
- clk  input  1  system clock; the only clock
- clr  input  1  reset, synchronous, active-high
- tick  input  1  one-cycle shift strobe from the clock divider, synchronous to clk
- start_valid  input  1  word available on data_in
- start_ready  output  1  controller can accept a word
- data_in  input  WIDTH  parallel word to shift out
- abort  input  1  terminate the current transfer
- sdout  output  1  serial bit to the shift register Din
- shift_en  output  1  shift strobe to the shift register
- shreg_clr  output  1  clear strobe to the shift register
- busy  output  1  transfer in progress
- done  output  1  one-cycle completion pulse
- bit_cnt  output  $clog2(WIDTH+1)  bits shifted so far in the current word

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE
  - start_ready=1, busy=0.
  - On start_valid&start_ready, capture data_in into an internal word register and set bit_cnt=0.
  - Next state is LOAD if CLR_FIRST=1, else SHIFT.
- LOAD
  - shreg_clr=1 for exactly this one cycle; shift_en=0.
  - Next state is SHIFT unconditionally; a tick during LOAD is ignored.
- SHIFT
  - sdout is registered and holds the current bit, selected per MSB_FIRST.
  - shift_en = tick & (state==SHIFT) & ~abort (combinational).
  - On each cycle with shift_en=1: bit_cnt increments, the word register advances so sdout shows the next bit on the following cycle.
  - When the shift_en cycle brings bit_cnt to WIDTH, next state is DONE.
- DONE
  - done=1 for one cycle; bit_cnt holds WIDTH.
  - Next state is IDLE; start_ready returns to 1 one cycle after done.
- busy=1 in LOAD, SHIFT and DONE.
- abort
  - In LOAD or SHIFT: next state is IDLE; no done pulse; bit_cnt keeps its value; the word register is discarded.
  - abort overrides a same-cycle tick (shift_en=0).
  - abort in DONE or IDLE has no effect.
- start_valid outside IDLE is ignored; the word is not queued.
- data_in is sampled only on the handshake cycle; later changes have no effect.
- Word register is WIDTH bits; the shift fills with 0. bit_cnt saturates at WIDTH and never wraps.

## Timing
- Reset values:
  - state=IDLE, start_ready=1, busy=0, done=0, shift_en=0, shreg_clr=0, sdout=0, bit_cnt=0, word register=0.
  - clr has priority over every other input, in any state including mid-transfer.
  - Mid-transfer reset issues no further shift_en or done.
- Handshake at cycle T:
  - CLR_FIRST=1: shreg_clr at T+1, SHIFT from T+2.
  - CLR_FIRST=0: SHIFT from T+1.
- sdout is valid from the first SHIFT cycle and is stable in every cycle where shift_en=1.
- Latency to done = setup (1 or 0 cycles) + cycles to the WIDTH-th tick + 1. With a tick every cycle, CLR_FIRST=1, WIDTH=4: shift_en at T+2..T+5, done at T+6, start_ready at T+7.
- Minimum back-to-back: a new handshake is accepted in the cycle after done deasserts.
- shift_en and shreg_clr are never high in the same cycle.

## Test plan
- Reset: clr=1 for 2 cycles mid-SHIFT -> all outputs at reset values the cycle after, no done pulse.
- WIDTH=4, MSB_FIRST=1, CLR_FIRST=1, data_in=4'b1011, tick every 3rd cycle:
  - shreg_clr once, then exactly 4 shift_en pulses with sdout=1,0,1,1.
  - Downstream register model reads Q=4'b1011; done one cycle after the 4th shift_en.
- MSB_FIRST=0, CLR_FIRST=0, data_in=4'b0001, tick every cycle -> sdout sequence 1,0,0,0; shreg_clr never asserted; done at T+5.
- abort asserted on the same cycle as the 2nd tick -> only 1 shift_en; bit_cnt=1; IDLE next cycle; no done; start_ready=1.
- start_valid held high continuously with two words -> second word accepted only the cycle start_ready returns high; no overlap of busy periods; data changes during SHIFT ignored.
- Tick during LOAD and tick during DONE -> no shift_en, bit_cnt unchanged; total shift_en count per word equals WIDTH.
